// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// PWM receiver/decoder. The block samples an asynchronous PWM input and
// measures the high time and the period in prescaled ticks. It emits one
// measurement per complete rising-to-rising period. If no edge arrives for
// TIMEOUT ticks it raises stuck and records the input level.
//
// Optional feature (compile-time macro): PWM_GLITCH_FILTER_EN
//   defined   : a glitch filter sits between the synchronizer and edge
//               detection. The level changes only after FILT_LEN consecutive
//               equal samples. Edge latency becomes 3+FILT_LEN cycles.
//   undefined : the synchronized level feeds edge detection directly, with
//               3-cycle edge latency.
//
// Ports
//   sys_clk      in   system clock
//   sys_rst_n    in   synchronous active-low reset (clears everything)
//   pwm_in       in   PWM input, asynchronous to sys_clk
//   clr          in   synchronous clear; like reset but keeps the synchronizer
//   high_ticks   out  high time of the last complete period, in ticks
//   period_ticks out  length of the last complete period, in ticks
//   meas_valid   out  one-cycle pulse when high_ticks/period_ticks update
//   locked       out  a complete period was captured since reset/clr/stuck
//   stuck        out  no edge seen for TIMEOUT ticks
//   stuck_level  out  synchronized input level when stuck was raised
//   dbg_state    out  current FSM state (S_IDLE=0, S_HIGH=1, S_LOW=2)
//
// Output protocol: meas_valid is a valid-only pulse with no ready. The
// high_ticks/period_ticks pair is valid in the cycle meas_valid is high, and
// the pair holds its value until the next pulse, a reset or a clr.
// -----------------------------------------------------------------------------
module pwm_capture #(
    parameter int TICK_DIV = 5000,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 2000,
    parameter int FILT_LEN = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pwm_in,
    input  logic             clr,
    output logic [CNT_W-1:0] high_ticks,
    output logic [CNT_W-1:0] period_ticks,
    output logic             meas_valid,
    output logic             locked,
    output logic             stuck,
    output logic             stuck_level,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(TIMEOUT);

`ifdef PWM_GLITCH_FILTER_EN
    localparam int PRIME_LEN = 4;
`else
    localparam int PRIME_LEN = 3;
`endif

    // -------------------------------------------------------------------------
    // Synchronizer, optional filter, delay register and edge detection.
    // These registers are cleared only by reset, never by clr.
    // -------------------------------------------------------------------------
    logic                 sync1_q, sync2_q, dly_q;
    logic [PRIME_LEN-1:0] prime_q;
    logic                 lvl;
    logic                 edge_en;
    logic                 rise;
    logic                 fall;

    // prime_q fills with ones after reset. Edges stay masked until every
    // stage between pwm_in and dly_q holds a real sample. Without this mask,
    // an input that is high at reset would give a false rising edge and
    // start a partial period.
    assign edge_en = prime_q[PRIME_LEN-1];

`ifdef PWM_GLITCH_FILTER_EN
    localparam int FCNT_W = $clog2(FILT_LEN + 1);

    logic              filt_q, filt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // fcnt_q counts consecutive samples that differ from the filtered level.
    // While the pipeline is priming, the filter loads the synced level
    // directly so that the reset value of 0 is never reported as a real edge.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (!prime_q[2]) begin
            filt_d = sync2_q;
        end else if (sync2_q != filt_q) begin
            if (fcnt_q == FCNT_W'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            prime_q <= '0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            dly_q   <= lvl;
            prime_q <= {prime_q[PRIME_LEN-2:0], 1'b1};
        end
    end

    assign rise = edge_en &  lvl & ~dly_q;
    assign fall = edge_en & ~lvl &  dly_q;

    // -------------------------------------------------------------------------
    // Tick generator. A rising edge restarts the prescaler, so every tick
    // boundary is phase-aligned to the start of the period.
    // -------------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (clr || rise || tick) begin
            tick_cnt_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Measurement FSM, accumulators, stall detection and output registers.
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   high_acc_q, high_acc_d;
    logic [CNT_W-1:0]   period_acc_q, period_acc_d;
    logic [CNT_W-1:0]   high_ticks_q, high_ticks_d;
    logic [CNT_W-1:0]   period_ticks_q, period_ticks_d;
    logic               meas_valid_q, meas_valid_d;
    logic               locked_q, locked_d;
    logic               stuck_q, stuck_d;
    logic               stuck_level_q, stuck_level_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0]   high_sat, period_sat;

    // The accumulators saturate at all-ones instead of wrapping.
    always_comb begin
        high_sat   = high_acc_q;
        period_sat = period_acc_q;
        if (tick && !(&high_acc_q)) begin
            high_sat = high_acc_q + 1'b1;
        end
        if (tick && !(&period_acc_q)) begin
            period_sat = period_acc_q + 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        high_acc_d     = high_acc_q;
        period_acc_d   = period_acc_q;
        high_ticks_d   = high_ticks_q;
        period_ticks_d = period_ticks_q;
        meas_valid_d   = 1'b0;
        locked_d       = locked_q;
        stuck_d        = stuck_q;
        stuck_level_d  = stuck_level_q;
        stall_d        = stall_q;

        if (clr) begin
            state_d        = S_IDLE;
            high_acc_d     = '0;
            period_acc_d   = '0;
            high_ticks_d   = '0;
            period_ticks_d = '0;
            locked_d       = 1'b0;
            stuck_d        = 1'b0;
            stuck_level_d  = 1'b0;
            stall_d        = '0;
        end else begin
            // A tick in the same cycle as an edge belongs to the phase that
            // ends, so the saturated increments are taken before the edge
            // handling below uses or clears them.
            if (state_q != S_IDLE) begin
                period_acc_d = period_sat;
            end
            if (state_q == S_HIGH) begin
                high_acc_d = high_sat;
            end

            if (rise || fall) begin
                stall_d = '0;
                stuck_d = 1'b0;
            end else if (tick && (stall_q != STALL_MAX)) begin
                stall_d = stall_q + 1'b1;
                if (stall_q == STALL_LAST) begin
                    // The input is stuck. Drop the partial period and wait
                    // for a fresh rising edge.
                    stuck_d       = 1'b1;
                    stuck_level_d = lvl;
                    locked_d      = 1'b0;
                    state_d       = S_IDLE;
                    high_acc_d    = '0;
                    period_acc_d  = '0;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_d      = S_HIGH;
                        high_acc_d   = '0;
                        period_acc_d = '0;
                    end
                end
                S_HIGH: begin
                    if (rise) begin
                        // Cannot follow a rise without a fall in between.
                        // If it happens anyway, restart the measurement.
                        high_acc_d   = '0;
                        period_acc_d = '0;
                    end else if (fall) begin
                        state_d = S_LOW;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        high_ticks_d   = high_acc_q;
                        period_ticks_d = period_sat;
                        meas_valid_d   = 1'b1;
                        locked_d       = 1'b1;
                        high_acc_d     = '0;
                        period_acc_d   = '0;
                        state_d        = S_HIGH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q        <= S_IDLE;
            tick_cnt_q     <= '0;
            high_acc_q     <= '0;
            period_acc_q   <= '0;
            high_ticks_q   <= '0;
            period_ticks_q <= '0;
            meas_valid_q   <= 1'b0;
            locked_q       <= 1'b0;
            stuck_q        <= 1'b0;
            stuck_level_q  <= 1'b0;
            stall_q        <= '0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            high_acc_q     <= high_acc_d;
            period_acc_q   <= period_acc_d;
            high_ticks_q   <= high_ticks_d;
            period_ticks_q <= period_ticks_d;
            meas_valid_q   <= meas_valid_d;
            locked_q       <= locked_d;
            stuck_q        <= stuck_d;
            stuck_level_q  <= stuck_level_d;
            stall_q        <= stall_d;
        end
    end

    assign high_ticks   = high_ticks_q;
    assign period_ticks = period_ticks_q;
    assign meas_valid   = meas_valid_q;
    assign locked       = locked_q;
    assign stuck        = stuck_q;
    assign stuck_level  = stuck_level_q;
    assign dbg_state    = state_q;

endmodule
